// File: rtl/ofmap_writeback_if.sv
// Row input and GLB write port of the ofmap writeback stage.
// master: the writeback stage; slave: the accumulator/GLB environment.
interface ofmap_writeback_if #(
   parameter int unsigned PE_SIZE    = 4,
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ADDR_WIDTH = 10
);
   logic                            ofmap_valid;
   logic [DATA_WIDTH*PE_SIZE-1:0]   ofmap_row;
   logic                            glb_valid;
   logic                            glb_ready;
   logic [ADDR_WIDTH-1:0]           glb_addr;
   logic [DATA_WIDTH*PE_SIZE-1:0]   glb_wdata;

   modport master (
      input  ofmap_valid, ofmap_row, glb_ready,
      output glb_valid, glb_addr, glb_wdata
   );

   modport slave (
      output ofmap_valid, ofmap_row, glb_ready,
      input  glb_valid, glb_addr, glb_wdata
   );
endinterface

// File: rtl/ofmap_writeback.sv
// ofmap_writeback: per-lane ReLU, small row FIFO and GLB writeback of one
// ofmap tile, with a tile FSM counting accepted and written rows.
module ofmap_writeback #(
   parameter int unsigned PE_SIZE    = 4,
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ADDR_WIDTH = 10,
   parameter int unsigned BUF_DEPTH  = 4,
   parameter bit          RELU_EN    = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start_i,
   input  logic [ADDR_WIDTH-1:0] base_addr_i,
   input  logic [ADDR_WIDTH-1:0] row_num_i,
   ofmap_writeback_if.master     wb,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  overflow_o
);
   localparam int unsigned ROW_W = DATA_WIDTH * PE_SIZE;
   localparam int unsigned PTR_W = $clog2(BUF_DEPTH);
   localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t                state_q;
   logic                  busy_q, done_q, overflow_q;
   logic [ADDR_WIDTH-1:0] base_q, rows_q;
   logic [ADDR_WIDTH-1:0] acc_q, acc_d;
   logic [ADDR_WIDTH-1:0] wr_q, wr_d;

   logic [ROW_W-1:0]      data_q [BUF_DEPTH];
   logic [ADDR_WIDTH-1:0] addr_q [BUF_DEPTH];
   logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]      cnt_q, cnt_d;

   logic [ROW_W-1:0]      relu_row;
   logic                  full, pop, push_req, push, drop_full, drop_any, last_xfer;

   // Clamp negative lanes to zero before they enter the buffer.
   always_comb begin
      relu_row = wb.ofmap_row;
      for (int unsigned k = 0; k < PE_SIZE; k++) begin
         if (RELU_EN && wb.ofmap_row[DATA_WIDTH*(PE_SIZE-k)-1])
            relu_row[DATA_WIDTH*(PE_SIZE-k)-1 -: DATA_WIDTH] = '0;
      end
   end

   // Push/pop/drop decisions and next values of the row counters.
   always_comb begin
      full      = (cnt_q == CNT_W'(BUF_DEPTH));
      pop       = (cnt_q != '0) && wb.glb_ready;
      push_req  = wb.ofmap_valid && (state_q == S_RUN) && (acc_q < rows_q);
      // A full buffer still takes a row when the head leaves in the same cycle.
      push      = push_req && (!full || pop);
      drop_full = push_req && full && !pop;
      drop_any  = wb.ofmap_valid && !push;
      last_xfer = pop && (state_q == S_RUN) && ((wr_q + ADDR_WIDTH'(1)) == rows_q);

      cnt_d = cnt_q;
      if (push && !pop)
         cnt_d = cnt_q + CNT_W'(1);
      else if (pop && !push)
         cnt_d = cnt_q - CNT_W'(1);

      acc_d = push_req ? acc_q + ADDR_WIDTH'(1) : acc_q;
      // A row lost to a full buffer consumes its address slot as if written,
      // so the tile still completes.
      wr_d  = (pop || drop_full) ? wr_q + ADDR_WIDTH'(1) : wr_q;
   end

   // Row FIFO; each entry keeps its own GLB address so a head that is waiting
   // on ready never changes address when later rows are dropped.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
            data_q[i] <= '0;
            addr_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (push) begin
            data_q[wr_ptr_q] <= relu_row;
            addr_q[wr_ptr_q] <= base_q + acc_q;
            wr_ptr_q         <= wr_ptr_q + PTR_W'(1);
         end
         if (pop)
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         cnt_q <= cnt_d;
      end
   end

   // Tile FSM with registered busy/done/overflow.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         overflow_q <= 1'b0;
         base_q     <= '0;
         rows_q     <= '0;
         acc_q      <= '0;
         wr_q       <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start_i) begin
                  base_q     <= base_addr_i;
                  rows_q     <= row_num_i;
                  acc_q      <= '0;
                  wr_q       <= '0;
                  overflow_q <= 1'b0;
                  busy_q     <= 1'b1;
                  if (row_num_i == '0) begin
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= S_RUN;
                  end
               end
            end
            S_RUN: begin
               acc_q <= acc_d;
               wr_q  <= wr_d;
               if (last_xfer) begin
                  state_q <= S_DONE;
                  done_q  <= 1'b1;
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
         // A row lost in the same cycle as a start still flags the new tile.
         if (drop_any)
            overflow_q <= 1'b1;
      end
   end

   assign wb.glb_valid = (cnt_q != '0);
   assign wb.glb_addr  = addr_q[rd_ptr_q];
   assign wb.glb_wdata = data_q[rd_ptr_q];
   assign busy_o       = busy_q;
   assign done_o       = done_q;
   assign overflow_o   = overflow_q;

endmodule

// File: tb/tb_ofmap_writeback.sv
// Bench for ofmap_writeback: directed tiles from the test plan plus random
// tiles, all compared cycle by cycle against a queue-based reference model.
module tb_ofmap_writeback;
   localparam int unsigned PE    = 4;
   localparam int unsigned DW    = 8;
   localparam int unsigned AW    = 10;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned RW    = PE * DW;

   typedef struct {
      logic [AW-1:0] addr;
      logic [RW-1:0] data;
   } wr_t;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          start = 1'b0;
   logic [AW-1:0] base = '0;
   logic [AW-1:0] rows = '0;
   logic          busy, done, ovf;

   int nchk = 0;
   int nerr = 0;

   // reference model state: 0 idle, 1 running, 2 done
   int            m_phase = 0;
   int            m_acc = 0, m_wr = 0, m_rows = 0;
   logic [AW-1:0] m_base = '0;
   logic          m_ovf = 1'b0;
   wr_t           mq[$];

   // transfers actually seen on the GLB port
   logic [AW-1:0] log_a[$];
   logic [RW-1:0] log_d[$];

   ofmap_writeback_if #(.PE_SIZE(PE), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

   ofmap_writeback #(
      .PE_SIZE(PE), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BUF_DEPTH(DEPTH), .RELU_EN(1'b1)
   ) dut (
      .clk(clk), .rst(rst), .start_i(start), .base_addr_i(base), .row_num_i(rows),
      .wb(bus), .busy_o(busy), .done_o(done), .overflow_o(ovf)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      nchk++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [RW-1:0] relu(input logic [RW-1:0] r);
      logic [RW-1:0] o;
      logic [DW-1:0] b;
      o = r;
      for (int k = 0; k < PE; k++) begin
         b = r[k*DW +: DW];
         if ($signed(b) < 0) o[k*DW +: DW] = '0;
      end
      return o;
   endfunction

   task automatic model_reset();
      m_phase = 0; m_acc = 0; m_wr = 0; m_rows = 0; m_base = '0; m_ovf = 1'b0;
      mq.delete();
   endtask

   task automatic compare_outputs();
      check("glb_valid", bus.glb_valid, mq.size() != 0);
      check("busy", busy, m_phase != 0);
      check("done", done, m_phase == 2);
      check("overflow", ovf, m_ovf);
      if (mq.size() != 0) begin
         check("glb_addr", bus.glb_addr, mq[0].addr);
         check("glb_wdata", bus.glb_wdata, mq[0].data);
      end
   endtask

   // one clock: apply inputs, advance the model over the edge, compare after it
   task automatic cyc(input bit st, input bit v, input logic [RW-1:0] r, input bit rdy,
                      input logic [AW-1:0] b, input logic [AW-1:0] n);
      int  sz, pre;
      bit  xfer;
      wr_t e;
      start = st; base = b; rows = n;
      bus.ofmap_valid = v; bus.ofmap_row = r; bus.glb_ready = rdy;
      if (bus.glb_valid && rdy) begin
         log_a.push_back(bus.glb_addr);
         log_d.push_back(bus.glb_wdata);
      end
      sz   = mq.size();
      xfer = (sz > 0) && rdy;
      pre  = m_phase;
      if (xfer) begin
         mq.delete(0);
         m_wr++;
      end
      case (pre)
         0: if (st) begin
               m_base = b; m_rows = int'(n); m_acc = 0; m_wr = 0; m_ovf = 1'b0;
               m_phase = (n == 0) ? 2 : 1;
            end
         1: if (xfer && m_wr == m_rows) m_phase = 2;
         default: m_phase = 0;
      endcase
      if (v) begin
         if (pre == 1 && m_acc < m_rows) begin
            if (sz == DEPTH && !xfer) begin
               m_ovf = 1'b1;
               m_wr++;
            end else begin
               e.addr = m_base + AW'(m_acc);
               e.data = relu(r);
               mq.push_back(e);
            end
            m_acc++;
         end else begin
            m_ovf = 1'b1;
         end
      end
      @(posedge clk);
      #1;
      compare_outputs();
   endtask

   task automatic drain(input int maxc);
      int n = 0;
      while ((m_phase != 0 || busy) && n < maxc) begin
         cyc(1'b0, 1'b0, '0, 1'b1, base, rows);
         n++;
      end
      check("drain_timeout", n >= maxc, 1'b0);
   endtask

   task automatic clear_log();
      log_a.delete();
      log_d.delete();
   endtask

   initial begin
      logic [RW-1:0] r;
      bit            v, rdy, st;
      int            n;
      logic [AW-1:0] b, nr;

      bus.ofmap_valid = 1'b0; bus.ofmap_row = '0; bus.glb_ready = 1'b0;

      // asynchronous reset before any clock edge
      #1 rst = 1'b1;
      #1;
      check("rst_glb_valid", bus.glb_valid, 1'b0);
      check("rst_glb_addr", bus.glb_addr, '0);
      check("rst_glb_wdata", bus.glb_wdata, '0);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_overflow", ovf, 1'b0);
      @(posedge clk);
      #1 rst = 1'b0;
      model_reset();

      // basic tile with ReLU on the second row
      clear_log();
      cyc(1, 0, '0, 1, 10'h010, 10'd3);
      check("start_busy", busy, 1'b1);
      cyc(0, 1, 32'h01020304, 1, 10'h010, 10'd3);
      cyc(0, 1, 32'h7F80FF00, 1, 10'h010, 10'd3);
      cyc(0, 1, 32'h05060708, 1, 10'h010, 10'd3);
      drain(20);
      check("basic_count", log_a.size(), 3);
      if (log_a.size() == 3) begin
         check("basic_a0", log_a[0], 10'h010); check("basic_d0", log_d[0], 32'h01020304);
         check("basic_a1", log_a[1], 10'h011); check("basic_d1", log_d[1], 32'h7F000000);
         check("basic_a2", log_a[2], 10'h012); check("basic_d2", log_d[2], 32'h05060708);
      end
      check("basic_overflow", ovf, 1'b0);

      // backpressure: 4 rows held while ready is low
      clear_log();
      cyc(1, 0, '0, 0, 10'h100, 10'd4);
      for (int i = 0; i < 4; i++) cyc(0, 1, $urandom, 0, 10'h100, 10'd4);
      cyc(0, 0, '0, 0, 10'h100, 10'd4);
      cyc(0, 0, '0, 0, 10'h100, 10'd4);
      check("bp_no_write", log_a.size(), 0);
      check("bp_overflow", ovf, 1'b0);
      drain(20);
      check("bp_count", log_a.size(), 4);
      for (int i = 0; i < log_a.size(); i++) check("bp_addr", log_a[i], 10'h100 + i);

      // overflow: 6 rows into a 4-deep buffer with ready low
      clear_log();
      cyc(1, 0, '0, 0, 10'h200, 10'd6);
      for (int i = 0; i < 6; i++) cyc(0, 1, $urandom, 0, 10'h200, 10'd6);
      check("ovf_set", ovf, 1'b1);
      drain(20);
      check("ovf_count", log_a.size(), 4);
      check("ovf_sticky", ovf, 1'b1);

      // next start clears overflow; tile also wraps the address space
      clear_log();
      cyc(1, 0, '0, 1, 10'h3FE, 10'd3);
      check("ovf_cleared", ovf, 1'b0);
      for (int i = 0; i < 3; i++) cyc(0, 1, $urandom, 1, 10'h3FE, 10'd3);
      drain(20);
      check("wrap_count", log_a.size(), 3);
      if (log_a.size() == 3) begin
         check("wrap_a0", log_a[0], 10'h3FE);
         check("wrap_a1", log_a[1], 10'h3FF);
         check("wrap_a2", log_a[2], 10'h000);
      end

      // full buffer with push and pop in the same cycle
      clear_log();
      cyc(1, 0, '0, 0, 10'h050, 10'd10);
      for (int i = 0; i < 4; i++) cyc(0, 1, $urandom, 0, 10'h050, 10'd10);
      for (int i = 0; i < 6; i++) cyc(0, 1, $urandom, 1, 10'h050, 10'd10);
      drain(20);
      check("full_overflow", ovf, 1'b0);
      check("full_count", log_a.size(), 10);
      for (int i = 0; i < log_a.size(); i++) check("full_addr", log_a[i], 10'h050 + i);

      // zero-row tile
      clear_log();
      cyc(1, 0, '0, 1, 10'h020, 10'd0);
      check("zero_done", done, 1'b1);
      cyc(0, 0, '0, 1, 10'h020, 10'd0);
      cyc(0, 0, '0, 1, 10'h020, 10'd0);
      check("zero_no_write", log_a.size(), 0);
      check("zero_idle", busy, 1'b0);

      // reset in the middle of a tile with rows buffered and overflow set
      cyc(1, 0, '0, 0, 10'h0AA, 10'd2);
      for (int i = 0; i < 3; i++) cyc(0, 1, 32'h11223344 + i, 0, 10'h0AA, 10'd2);
      check("pre_rst_overflow", ovf, 1'b1);
      #2 rst = 1'b1;
      #1;
      check("mid_rst_glb_valid", bus.glb_valid, 1'b0);
      check("mid_rst_glb_addr", bus.glb_addr, '0);
      check("mid_rst_glb_wdata", bus.glb_wdata, '0);
      check("mid_rst_busy", busy, 1'b0);
      check("mid_rst_done", done, 1'b0);
      check("mid_rst_overflow", ovf, 1'b0);
      bus.ofmap_valid = 1'b0; bus.glb_ready = 1'b0; start = 1'b0;
      @(posedge clk);
      #1 rst = 1'b0;
      model_reset();
      cyc(0, 0, '0, 1, 10'h0AA, 10'd2);

      // random tiles: random valid/ready, stray starts while busy, idle gaps
      for (int t = 0; t < 40; t++) begin
         for (int g = $urandom_range(0, 3); g > 0; g--)
            cyc(0, $urandom_range(0, 9) == 0, $urandom, 1, base, rows);
         b  = AW'($urandom);
         nr = AW'($urandom_range(1, 12));
         cyc(1, 0, '0, $urandom_range(0, 1), b, nr);
         n = 0;
         while (m_phase != 0 && n < 300) begin
            v   = $urandom_range(0, 99) < 70;
            rdy = $urandom_range(0, 99) < 60;
            st  = $urandom_range(0, 19) == 0;
            r   = $urandom;
            cyc(st, v, r, rdy, b, nr);
            n++;
         end
         check("rand_timeout", n >= 300, 1'b0);
      end

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
